i2c_phase_clk_gen: RTL and testbench

Parametrised I2C bit-clock generator for the single-master I2C core, clocked from PLL_CLK.
- Divides PLL_CLK into four quarter-phases per SCL period.
- Drives the internal SCL level and per-phase tick strobes that the bit engine uses to place SDA changes and samples.
- Supports slave clock stretching with an optional timeout, glitch-free divider updates, and a clean stop at the period boundary.
- Keeps the single-cycle I2C_CLK period strobe so existing consumers still work.

---
 rtl/i2c_phase_clk_gen.sv | 155 +++++++++++++++
 tb/tb_i2c_phase_clk_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/i2c_phase_clk_gen.sv
// rtl/i2c_phase_clk_gen.sv - I2C quarter-phase SCL generator with clock stretching and timeout
module i2c_phase_clk_gen #(
   parameter int DIV_W       = 16,
   parameter int TO_W        = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic             PLL_CLK,
   input  logic             RESETn,
   input  logic             EN,
   input  logic [DIV_W-1:0] CLK_div_N,
   input  logic             STRETCH_EN,
   input  logic [TO_W-1:0]  STRETCH_TO,
   input  logic             SCL_IN,
   output logic             SCL_O,
   output logic [1:0]       PHASE,
   output logic             TICK,
   output logic             I2C_CLK,
   output logic             BUSY,
   output logic             STRETCH,
   output logic             TIMEOUT
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_WAIT_HI
   } state_t;

   state_t                 state;
   logic [DIV_W-1:0]       cnt;
   logic [DIV_W-1:0]       div_q;
   logic [TO_W-1:0]        to_cnt;
   logic [SYNC_STAGES-1:0] scl_sync;

   logic                   scl_s;
   logic                   scl_next;
   logic                   hold;
   logic                   quarter_end;
   logic                   to_hit;
   logic [TO_W:0]          to_nxt;

   // scl_s is the synchronised bus level; scl_next is the value scl_s takes next
   // cycle, which lets the registered STRETCH flag fall in the same cycle that
   // counting resumes.
   assign scl_s       = scl_sync[SYNC_STAGES-1];
   assign scl_next    = scl_sync[SYNC_STAGES-2];
   assign hold        = (state == ST_WAIT_HI) && !scl_s;
   assign quarter_end = (cnt == div_q);
   assign to_nxt      = {1'b0, to_cnt} + (TO_W+1)'(1);
   assign to_hit      = (STRETCH_TO != '0) && (to_nxt == {1'b0, STRETCH_TO});

   // Multi-flop synchroniser for the asynchronous SCL bus level.
   always_ff @(posedge PLL_CLK) begin
      if (!RESETn) begin
         scl_sync <= '0;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_IN};
      end
   end

   // Phase sequencer: quarter counting, stretch hold, timeout abort and period-boundary stop.
   always_ff @(posedge PLL_CLK) begin
      if (!RESETn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         div_q   <= '0;
         to_cnt  <= '0;
         SCL_O   <= 1'b1;
         PHASE   <= 2'd0;
         TICK    <= 1'b0;
         I2C_CLK <= 1'b0;
         BUSY    <= 1'b0;
         STRETCH <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         TICK    <= 1'b0;
         I2C_CLK <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt     <= '0;
               to_cnt  <= '0;
               SCL_O   <= 1'b1;
               PHASE   <= 2'd0;
               BUSY    <= 1'b0;
               STRETCH <= 1'b0;
               if (EN) begin
                  div_q   <= CLK_div_N;
                  TICK    <= 1'b1;
                  I2C_CLK <= 1'b1;
                  BUSY    <= 1'b1;
                  TIMEOUT <= 1'b0;
                  SCL_O   <= 1'b0;
                  state   <= ST_RUN;
               end
            end
            default: begin
               if (hold) begin
                  // Slave still holding SCL low: phase 2 does not advance.
                  cnt <= '0;
                  if (to_hit) begin
                     TIMEOUT <= 1'b1;
                     state   <= ST_IDLE;
                     SCL_O   <= 1'b1;
                     PHASE   <= 2'd0;
                     BUSY    <= 1'b0;
                     STRETCH <= 1'b0;
                     to_cnt  <= '0;
                  end else begin
                     STRETCH <= !scl_next;
                     if (STRETCH_TO != '0) begin
                        to_cnt <= to_nxt[TO_W-1:0];
                     end
                  end
               end else begin
                  // Normal counting cycle (RUN, or the first released WAIT_HI cycle).
                  state   <= ST_RUN;
                  STRETCH <= 1'b0;
                  to_cnt  <= '0;
                  if (!quarter_end) begin
                     cnt <= cnt + DIV_W'(1);
                  end else begin
                     cnt   <= '0;
                     PHASE <= PHASE + 2'd1;
                     TICK  <= 1'b1;
                     case (PHASE)
                        2'd0: SCL_O <= 1'b0;
                        2'd1: begin
                           SCL_O <= 1'b1;
                           if (STRETCH_EN) begin
                              state   <= ST_WAIT_HI;
                              STRETCH <= !scl_next;
                           end
                        end
                        2'd2: SCL_O <= 1'b1;
                        default: begin
                           // Period boundary: new divider takes effect or we stop cleanly.
                           if (EN) begin
                              div_q   <= CLK_div_N;
                              I2C_CLK <= 1'b1;
                              SCL_O   <= 1'b0;
                           end else begin
                              state <= ST_IDLE;
                              BUSY  <= 1'b0;
                              TICK  <= 1'b0;
                           end
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_phase_clk_gen.sv
// tb/tb_i2c_phase_clk_gen.sv - directed self-checking bench for i2c_phase_clk_gen
module tb_i2c_phase_clk_gen;

   localparam int DIV_W       = 16;
   localparam int TO_W        = 20;
   localparam int SYNC_STAGES = 2;

   logic             PLL_CLK = 1'b0;
   logic             RESETn;
   logic             EN;
   logic [DIV_W-1:0] CLK_div_N;
   logic             STRETCH_EN;
   logic [TO_W-1:0]  STRETCH_TO;
   logic             SCL_IN;
   logic             SCL_O;
   logic [1:0]       PHASE;
   logic             TICK;
   logic             I2C_CLK;
   logic             BUSY;
   logic             STRETCH;
   logic             TIMEOUT;

   logic             loop_en;
   logic             scl_force;
   int               tests_run = 0;
   int               failed    = 0;
   int               n;

   i2c_phase_clk_gen #(
      .DIV_W      (DIV_W),
      .TO_W       (TO_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .PLL_CLK   (PLL_CLK),
      .RESETn    (RESETn),
      .EN        (EN),
      .CLK_div_N (CLK_div_N),
      .STRETCH_EN(STRETCH_EN),
      .STRETCH_TO(STRETCH_TO),
      .SCL_IN    (SCL_IN),
      .SCL_O     (SCL_O),
      .PHASE     (PHASE),
      .TICK      (TICK),
      .I2C_CLK   (I2C_CLK),
      .BUSY      (BUSY),
      .STRETCH   (STRETCH),
      .TIMEOUT   (TIMEOUT)
   );

   always #5 PLL_CLK = ~PLL_CLK;

   assign SCL_IN = loop_en ? SCL_O : scl_force;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge PLL_CLK);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return TICK;
         1:       return I2C_CLK;
         default: return STRETCH;
      endcase
   endfunction

   task automatic wait_for(input int sel, output int cnt);
      cnt = 0;
      do begin
         @(negedge PLL_CLK);
         cnt++;
      end while (sig(sel) !== 1'b1 && cnt < 300);
   endtask

   initial begin
      RESETn     = 1'b0;
      EN         = 1'b0;
      CLK_div_N  = 16'd3;
      STRETCH_EN = 1'b0;
      STRETCH_TO = '0;
      loop_en    = 1'b1;
      scl_force  = 1'b0;
      step(3);
      check("reset_outputs", {SCL_O, PHASE, TICK, I2C_CLK, BUSY, STRETCH, TIMEOUT}, 8'b1000_0000);
      RESETn = 1'b1;
      step(1);
      check("idle_busy_scl", {SCL_O, BUSY}, 2'b10);

      // Test 1: divider 3, free running
      EN = 1'b1;
      step(1);
      check("start_vec", {I2C_CLK, TICK, BUSY, PHASE, SCL_O}, 6'b111_00_0);
      wait_for(0, n); check("t1_gap_p1", n, 4); check("t1_phase1", {PHASE, SCL_O}, 3'b01_0);
      wait_for(0, n); check("t1_gap_p2", n, 4); check("t1_phase2", {PHASE, SCL_O}, 3'b10_1);
      wait_for(0, n); check("t1_gap_p3", n, 4); check("t1_phase3", {PHASE, SCL_O}, 3'b11_1);
      wait_for(1, n); check("t1_gap_p0", n, 4); check("t1_phase0", {PHASE, SCL_O}, 3'b00_0);
      wait_for(1, n); check("t1_period", n, 16); check("t1_busy", BUSY, 1'b1);

      // Test 2: divider 0, then 7 written mid phase 1
      CLK_div_N = 16'd0;
      wait_for(1, n); check("t2_old_period", n, 16);
      wait_for(0, n); check("t2_tick_div0", n, 1); check("t2_phase1", PHASE, 2'd1);
      CLK_div_N = 16'd7;
      wait_for(1, n); check("t2_period_rest", n, 3);
      wait_for(1, n); check("t2_period_div7", n, 32);

      // Test 3: loopback stretching, divider 3 from next period
      CLK_div_N  = 16'd3;
      STRETCH_EN = 1'b1;
      loop_en    = 1'b1;
      wait_for(1, n); check("t3_period_div7_st", n, 34);
      wait_for(1, n); check("t3_period_div3_st", n, 18);
      wait_for(2, n); check("t3_stretch_at", n, 8); check("t3_stretch_phase", PHASE, 2'd2);
      step(1); check("t3_stretch_c1", STRETCH, 1'b1);
      step(1); check("t3_stretch_c2", STRETCH, 1'b0);
      wait_for(1, n); check("t3_rest", n, 8);

      // Test 4: slave holds SCL low 30 cycles, no timeout
      loop_en   = 1'b0;
      scl_force = 1'b0;
      wait_for(2, n); check("t4_stretch_at", n, 8);
      step(15); check("t4_mid_hold", {PHASE, STRETCH}, 3'b10_1);
      step(15); check("t4_c30_hold", {PHASE, STRETCH}, 3'b10_1);
      scl_force = 1'b1;
      step(1); check("t4_c31_stretch", STRETCH, 1'b1);
      step(1); check("t4_c32_stretch", STRETCH, 1'b0);
      wait_for(0, n); check("t4_phase2_tail", n, 4);
      check("t4_phase3_noto", {PHASE, TIMEOUT}, 3'b11_0);

      // Test 5: SCL stuck low, timeout 50
      STRETCH_TO = 20'd50;
      scl_force  = 1'b0;
      wait_for(2, n); check("t5_stretch_at", n, 12);
      EN = 1'b0;
      step(49); check("t5_c49", {PHASE, STRETCH, TIMEOUT, BUSY}, 5'b10_1_0_1);
      step(1);  check("t5_timeout", {SCL_O, PHASE, TICK, STRETCH, TIMEOUT, BUSY}, 7'b1_00_0_0_1_0);
      step(2);  check("t5_sticky", {TIMEOUT, BUSY}, 2'b10);
      EN      = 1'b1;
      loop_en = 1'b1;
      step(1);  check("t5_restart", {TIMEOUT, BUSY, I2C_CLK}, 3'b011);

      // Test 6: EN dropped in phase 1, then reset in phase 2
      wait_for(0, n); check("t6_p1", {n[7:0], PHASE}, {8'd4, 2'd1});
      EN = 1'b0;
      wait_for(0, n); check("t6_p2", {n[7:0], PHASE, STRETCH}, {8'd4, 2'd2, 1'b1});
      wait_for(0, n); check("t6_p3", {n[7:0], PHASE}, {8'd6, 2'd3});
      step(3); check("t6_busy_p3", BUSY, 1'b1);
      step(1); check("t6_stop", {SCL_O, PHASE, TICK, I2C_CLK, BUSY}, 6'b1_00_000);
      step(2); check("t6_stays_idle", {BUSY, I2C_CLK, TICK}, 3'b000);
      EN = 1'b1;
      step(1); check("t6_restart", {I2C_CLK, TICK, BUSY}, 3'b111);
      wait_for(0, n); check("t6_r_p1", n, 4);
      wait_for(0, n); check("t6_r_p2", {n[7:0], PHASE, STRETCH}, {8'd4, 2'd2, 1'b1});
      RESETn = 1'b0;
      step(1); check("t6_reset_mid", {SCL_O, PHASE, TICK, I2C_CLK, BUSY, STRETCH, TIMEOUT}, 8'b1000_0000);
      RESETn = 1'b1;
      EN     = 1'b0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
